disp_feeder: RTL and testbench
==============================

DISP_FEEDER -- requirements
Module: disp_feeder

Interface
REQ-001 Parameter ERR_HOLD, default 50000000, number of clk cycles the ERR message is held; legal range 1 to 2^32-1.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 value_in  input  9  signed two's-complement result from the calculator core.
REQ-005 dot_in  input  2  decimal-point digit position accompanying value_in.
REQ-006 ovf_in  input  1  core overflow/error flag accompanying value_in.
REQ-007 value_valid  input  1  value_in/dot_in/ovf_in are valid this cycle.
REQ-008 value_ready  output  1  block accepts a value this cycle; transfer occurs when value_valid and value_ready are both 1.
REQ-009 cmd_op  input  1  one-cycle request to show the "OP" prompt.
REQ-010 cmd_val  input  1  one-cycle request to show the "VAL" prompt.
REQ-011 msg  output  2  display message select: 00 number, 01 OP, 10 VAL, 11 ERR.
REQ-012 bin  output  8  magnitude to display.
REQ-013 sgn  output  1  1 = show minus sign.
REQ-014 dot  output  2  decimal-point position for the display.
REQ-015 wr_enable  output  1  one-cycle display write strobe.
REQ-016 led0_sel  output  1  display select, asserted together with wr_enable.

Function
REQ-017 All outputs SHALL be registered; FSM states SHALL be S_OP, S_VAL, S_LOAD, S_NUM, S_ERR.
REQ-018 value_ready SHALL be 1 in S_OP, S_VAL and S_NUM, and 0 in S_LOAD, S_ERR and while rst is 1.
REQ-019 On a transfer with ovf_in=0 and value_in != -256: next state S_LOAD; on that edge bin <= |value_in|, sgn <= 1 iff value_in < 0, dot <= dot_in, msg <= 00, wr_enable <= 1, led0_sel <= 1.
REQ-020 S_LOAD SHALL last exactly one cycle, then go to S_NUM with wr_enable <= 0 and led0_sel <= 0; bin, sgn, dot and msg hold.
REQ-021 wr_enable SHALL never be 1 on two consecutive cycles, since each strobe restarts the display refresh scan.
REQ-022 wr_enable SHALL only be asserted from S_LOAD; prompt and ERR changes change msg only.
REQ-023 A transfer with ovf_in=1 or value_in = -256 SHALL enter S_ERR: msg <= 11, sgn <= 0, dot <= 00, bin holds, no strobe, hold counter <= 0.
REQ-024 In S_ERR the counter SHALL increment each cycle; when it reaches ERR_HOLD-1 the FSM SHALL go to S_OP with msg <= 01, so ERR is visible for exactly ERR_HOLD cycles.
REQ-025 cmd_op in S_ERR SHALL abort the hold and go to S_OP on the next edge; cmd_val in S_ERR SHALL be ignored.
REQ-026 In S_OP, S_VAL or S_NUM: cmd_op SHALL set state S_OP, msg <= 01; cmd_val SHALL set state S_VAL, msg <= 10; dot <= 00 on either.
REQ-027 Same-cycle priority SHALL be transfer > cmd_op > cmd_val; lower-priority events in that cycle are dropped.
REQ-028 cmd_op/cmd_val in S_LOAD SHALL be dropped.
REQ-029 A new transfer in S_NUM SHALL repeat REQ-019/REQ-023; the minimum spacing between two strobes is therefore 2 cycles.
REQ-030 Magnitude arithmetic SHALL be performed at 9 bits; values -255..255 are displayable; zero SHALL give sgn=0.

Reset
REQ-031 While rst=1 at a clk edge: state <= S_OP, msg <= 01, bin <= 0, sgn <= 0, dot <= 00, wr_enable <= 0, led0_sel <= 0, hold counter <= 0.
REQ-032 rst SHALL override every in-flight operation, including S_LOAD (the strobe is cancelled) and S_ERR (the hold is abandoned).
REQ-033 value_ready SHALL first be 1 in the first cycle after rst deasserts.

Verification
REQ-034 Reset release, then idle -> msg=01, wr_enable=0, value_ready=1, bin=0.
REQ-035 value_in=-123, dot_in=01, valid for 1 cycle -> next cycle msg=00, bin=123, sgn=1, dot=01, wr_enable=led0_sel=1 for exactly 1 cycle, value_ready=0 for that cycle.
REQ-036 value_in=-256, with ERR_HOLD=4 -> msg=11 for exactly 4 cycles, value_ready=0, no strobe, then msg=01; repeat with ovf_in=1 and value_in=5 -> same response.
REQ-037 value_valid held high with values 10, 20, 30 -> strobes spaced 2 cycles apart with bin 10, 20, 30, never two consecutive strobe cycles.
REQ-038 cmd_op, cmd_val and a valid value_in=7 in the same cycle from S_VAL -> number path taken (msg=00, bin=7); cmd_val alone afterwards -> msg=10, no strobe.
REQ-039 rst asserted during S_LOAD and separately mid-ERR -> next cycle reset values of REQ-031, wr_enable=0.

Source files
------------

// File: rtl/disp_feeder_if.sv
// disp_feeder_if
// Bundles the value handshake, prompt commands and display-side outputs of
// disp_feeder.
//   slave  : the feeder's own view (value/command inputs, display outputs)
//   master : the driving side (calculator core plus display)
// Signals:
//   value_in[8:0]  signed result        dot_in[1:0]  decimal-point position
//   ovf_in         overflow/error flag  value_valid  value_in/dot_in/ovf_in valid
//   value_ready    value accepted       cmd_op       show "OP" prompt
//   cmd_val        show "VAL" prompt    msg[1:0]     00 num, 01 OP, 10 VAL, 11 ERR
//   bin[7:0]       magnitude            sgn          minus sign
//   dot[1:0]       decimal point        wr_enable    one-cycle write strobe
//   led0_sel       display select, asserted together with wr_enable
interface disp_feeder_if;
  logic [8:0] value_in;
  logic [1:0] dot_in;
  logic       ovf_in;
  logic       value_valid;
  logic       value_ready;
  logic       cmd_op;
  logic       cmd_val;
  logic [1:0] msg;
  logic [7:0] bin;
  logic       sgn;
  logic [1:0] dot;
  logic       wr_enable;
  logic       led0_sel;

  modport slave (
    input  value_in, dot_in, ovf_in, value_valid, cmd_op, cmd_val,
    output value_ready, msg, bin, sgn, dot, wr_enable, led0_sel
  );

  modport master (
    output value_in, dot_in, ovf_in, value_valid, cmd_op, cmd_val,
    input  value_ready, msg, bin, sgn, dot, wr_enable, led0_sel
  );
endinterface

// File: rtl/disp_feeder.sv
// disp_feeder
// Turns calculator results and prompt commands into display updates. A valid
// number produces a single write strobe and a one-cycle load phase; an
// overflow (or -256, which has no 8-bit magnitude) shows ERR for ERR_HOLD
// cycles and then falls back to the OP prompt.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  disp_feeder_if.slave (value handshake, commands, display outputs)
//
// state  | meaning
// S_OP   | "OP" prompt shown, accepting values
// S_VAL  | "VAL" prompt shown, accepting values
// S_LOAD | write strobe cycle after a number transfer, not accepting
// S_NUM  | number shown, accepting values
// S_ERR  | ERR shown, hold counter running, not accepting
module disp_feeder #(
  parameter int unsigned ERR_HOLD = 50000000
) (
  input logic         clk,
  input logic         rst,
  disp_feeder_if.slave bus
);

  localparam logic [2:0] S_OP   = 3'd0;
  localparam logic [2:0] S_VAL  = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_NUM  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [31:0] HOLD_LAST = 32'(ERR_HOLD - 1);

  logic [2:0]  state;
  logic [31:0] hold_cnt;
  logic        rdy_q;
  logic        transfer;
  logic        is_err;
  logic [7:0]  mag;

  // rdy_q tracks "next state accepts values"; gating with rst keeps ready
  // low during reset and lets it rise in the first cycle after release.
  assign bus.value_ready = rdy_q & ~rst;
  assign transfer        = bus.value_valid & bus.value_ready;
  assign is_err          = bus.ovf_in | (bus.value_in == 9'h100);
  // Negation at 9 bits; -256 is routed to ERR so 8 bits always suffice here.
  assign mag = bus.value_in[8] ? 8'(9'd0 - bus.value_in) : bus.value_in[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_OP;
      rdy_q         <= 1'b1;
      hold_cnt      <= '0;
      bus.msg       <= 2'b01;
      bus.bin       <= '0;
      bus.sgn       <= 1'b0;
      bus.dot       <= 2'b00;
      bus.wr_enable <= 1'b0;
      bus.led0_sel  <= 1'b0;
    end else begin
      bus.wr_enable <= 1'b0;
      bus.led0_sel  <= 1'b0;
      case (state)
        S_OP, S_VAL, S_NUM: begin
          if (transfer) begin
            rdy_q <= 1'b0;
            if (is_err) begin
              state    <= S_ERR;
              hold_cnt <= '0;
              bus.msg  <= 2'b11;
              bus.sgn  <= 1'b0;
              bus.dot  <= 2'b00;
            end else begin
              state         <= S_LOAD;
              bus.msg       <= 2'b00;
              bus.bin       <= mag;
              bus.sgn       <= bus.value_in[8];
              bus.dot       <= bus.dot_in;
              bus.wr_enable <= 1'b1;
              bus.led0_sel  <= 1'b1;
            end
          end else if (bus.cmd_op) begin
            state   <= S_OP;
            bus.msg <= 2'b01;
            bus.dot <= 2'b00;
          end else if (bus.cmd_val) begin
            state   <= S_VAL;
            bus.msg <= 2'b10;
            bus.dot <= 2'b00;
          end
        end
        S_LOAD: begin
          state <= S_NUM;
          rdy_q <= 1'b1;
        end
        S_ERR: begin
          if (bus.cmd_op || hold_cnt == HOLD_LAST) begin
            state   <= S_OP;
            rdy_q   <= 1'b1;
            bus.msg <= 2'b01;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end
        default: begin
          state   <= S_OP;
          rdy_q   <= 1'b1;
          bus.msg <= 2'b01;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_feeder.sv
module tb_disp_feeder;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  disp_feeder_if dif();
  disp_feeder #(.ERR_HOLD(HOLD)) dut (.clk(clk), .rst(rst), .bus(dif.slave));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the display should show, plus how long the
  // feeder remains unavailable (one busy cycle after a strobe, err_left
  // remaining ERR cycles).
  typedef struct packed {logic [7:0] bin; logic sgn; logic [1:0] dot;} exp_t;
  exp_t sbq[$];

  logic       m_live = 1'b0;
  logic [1:0] m_msg;
  logic [7:0] m_bin;
  logic       m_sgn;
  logic [1:0] m_dot;
  logic       m_strobe;
  logic       m_busy = 1'b0;
  int         err_left = 0;
  logic       m_free = 1'b1;
  logic       last_accept = 1'b0;
  logic       m_rdy;
  int         v;
  exp_t       e_push;

  always @(posedge clk) begin
    m_rdy = m_free && !rst;
    last_accept = 1'b0;
    if (rst) begin
      m_live = 1'b1; m_msg = 2'b01; m_bin = 8'd0; m_sgn = 1'b0; m_dot = 2'b00;
      m_strobe = 1'b0; m_busy = 1'b0; err_left = 0;
    end else if (m_live) begin
      m_strobe = 1'b0;
      if (dif.value_valid && m_rdy) begin
        last_accept = 1'b1;
        v = int'($signed(dif.value_in));
        if (dif.ovf_in || v == -256) begin
          m_msg = 2'b11; m_sgn = 1'b0; m_dot = 2'b00; err_left = HOLD;
        end else begin
          m_msg = 2'b00;
          m_bin = 8'((v < 0) ? -v : v);
          m_sgn = (v < 0);
          m_dot = dif.dot_in;
          m_strobe = 1'b1;
          m_busy = 1'b1;
          e_push.bin = m_bin; e_push.sgn = m_sgn; e_push.dot = m_dot;
          sbq.push_back(e_push);
        end
      end else if (m_busy) begin
        m_busy = 1'b0;
      end else if (err_left > 0) begin
        if (dif.cmd_op || err_left == 1) begin
          err_left = 0; m_msg = 2'b01;
        end else begin
          err_left--;
        end
      end else if (dif.cmd_op) begin
        m_msg = 2'b01; m_dot = 2'b00;
      end else if (dif.cmd_val) begin
        m_msg = 2'b10; m_dot = 2'b00;
      end
    end
    m_free = !(m_busy || err_left > 0);
  end

  // Per-cycle state checker
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    chk("value_ready", dif.value_ready, m_free && !rst);
    if (m_live) begin
      chk("msg", dif.msg, m_msg);
      chk("bin", dif.bin, m_bin);
      chk("sgn", dif.sgn, m_sgn);
      chk("dot", dif.dot, m_dot);
      chk("wr_enable", dif.wr_enable, m_strobe);
      chk("led0_sel", dif.led0_sel, m_strobe);
      chk("strobe_back2back", prev_we & dif.wr_enable, 0);
      prev_we = dif.wr_enable;
    end
  end

  // Scoreboard monitor: each strobe consumes one expected number
  exp_t e_pop;
  always @(negedge clk) begin
    if (dif.wr_enable === 1'b1) begin
      chk("sb_pending", sbq.size() > 0, 1);
      if (sbq.size() > 0) begin
        e_pop = sbq.pop_front();
        chk("sb_bin", dif.bin, e_pop.bin);
        chk("sb_sgn", dif.sgn, e_pop.sgn);
        chk("sb_dot", dif.dot, e_pop.dot);
        chk("sb_msg", dif.msg, 2'b00);
      end
    end
  end

  task automatic drive(input logic vld, input logic [8:0] val, input logic [1:0] d,
                       input logic o, input logic op, input logic cv, input logic r);
    dif.value_valid = vld; dif.value_in = val; dif.dot_in = d; dif.ovf_in = o;
    dif.cmd_op = op; dif.cmd_val = cv; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 9'd0, 2'd0, 0, 0, 0, 0);
  endtask

  initial begin
    int waited;
    logic [8:0] vals [3];
    vals[0] = 9'd10; vals[1] = 9'd20; vals[2] = 9'd30;

    dif.value_valid = 0; dif.value_in = 0; dif.dot_in = 0; dif.ovf_in = 0;
    dif.cmd_op = 0; dif.cmd_val = 0; rst = 1;
    #1;
    for (int i = 0; i < 3; i++) drive(0, 9'd0, 2'd0, 0, 0, 0, 1);
    idle(2);
    chk("reset_msg", dif.msg, 2'b01);
    chk("reset_ready", dif.value_ready, 1);
    chk("reset_bin", dif.bin, 0);

    // -123 with dot 01
    drive(1, 9'h185, 2'b01, 0, 0, 0, 0);
    chk("neg123_bin", dif.bin, 123);
    chk("neg123_sgn", dif.sgn, 1);
    chk("neg123_we", dif.wr_enable, 1);
    chk("neg123_ready", dif.value_ready, 0);
    idle(3);

    // -256 and ovf_in=1 both go to ERR
    drive(1, 9'h100, 2'b10, 0, 0, 0, 0);
    idle(HOLD + 2);
    drive(1, 9'd5, 2'b01, 1, 0, 0, 0);
    idle(HOLD + 2);

    // cmd_op aborts ERR, cmd_val ignored in ERR
    drive(1, 9'd0, 2'b00, 1, 0, 0, 0);
    drive(0, 9'd0, 2'b00, 0, 0, 1, 0);
    drive(0, 9'd0, 2'b00, 0, 1, 0, 0);
    idle(2);

    // back-to-back values with valid held high
    for (int k = 0; k < 3; k++) begin
      dif.value_valid = 1; dif.value_in = vals[k]; dif.dot_in = 0; dif.ovf_in = 0;
      waited = 0;
      do begin
        @(posedge clk); #1; waited++;
      end while (!last_accept && waited < 6);
      chk("hold_accept", last_accept, 1);
    end
    idle(3);

    // priority from S_VAL
    drive(0, 9'd0, 2'b00, 0, 0, 1, 0);
    drive(1, 9'd7, 2'b11, 0, 1, 1, 0);
    chk("prio_bin", dif.bin, 7);
    chk("prio_msg", dif.msg, 2'b00);
    drive(0, 9'd0, 2'b00, 0, 1, 1, 0);   // dropped in S_LOAD
    drive(0, 9'd0, 2'b00, 0, 0, 1, 0);
    chk("val_msg", dif.msg, 2'b10);
    idle(2);

    // reset during S_LOAD and mid-ERR
    drive(1, 9'd99, 2'b01, 0, 0, 0, 0);
    drive(0, 9'd0, 2'b00, 0, 0, 0, 1);
    chk("rst_load_we", dif.wr_enable, 0);
    chk("rst_load_bin", dif.bin, 0);
    idle(2);
    drive(1, 9'h100, 2'b00, 0, 0, 0, 0);
    idle(1);
    drive(0, 9'd0, 2'b00, 0, 0, 0, 1);
    chk("rst_err_msg", dif.msg, 2'b01);
    idle(2);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      logic [8:0] rv;
      rv = 9'($urandom);
      if ($urandom_range(0, 15) == 0) rv = 9'h100;
      drive($urandom_range(0, 2) != 0, rv, 2'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 99) == 0);
    end
    idle(HOLD + 3);

    chk("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
